// File: rtl/ysyx_25020047_pkg.sv
// Shared encodings for the data-memory responder and its lane-align helper.
package ysyx_25020047_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
   } dmem_req_t;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load extension
// and misalignment / illegal-size detection.
module ysyx_25020047_lsu_align
   import ysyx_25020047_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be_c,
   output logic [31:0] wdata_rep_c,
   output logic [31:0] rdata_ext_c,
   output logic        misalign_c,
   output logic        bad_size_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be_c        = 4'b0000;
      wdata_rep_c = '0;
      rdata_ext_c = '0;
      misalign_c  = 1'b0;
      bad_size_c  = 1'b0;
      byte_sel    = rword[{addr_lo, 3'b000} +: 8];
      half_sel    = addr_lo[1] ? rword[31:16] : rword[15:0];
      unique case (size)
         SZ_B: begin
            be_c        = 4'b0001 << addr_lo;
            wdata_rep_c = {4{wdata[7:0]}};
            rdata_ext_c = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         end
         SZ_H: begin
            misalign_c  = addr_lo[0];
            be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_rep_c = {2{wdata[15:0]}};
            rdata_ext_c = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         end
         SZ_W: begin
            misalign_c  = |addr_lo;
            be_c        = 4'b1111;
            wdata_rep_c = wdata;
            rdata_ext_c = rword;
         end
         default: bad_size_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/ysyx_25020047_dmem.sv
// Multi-cycle data-memory responder with valid/ready request and response channels.
// Define YSYX_25020047_DMEM_RAND_DELAY_EN to stretch BUSY by an LFSR-driven 0..3 cycles.
module ysyx_25020047_dmem
   import ysyx_25020047_pkg::*;
#(
   parameter logic [31:0] BASE        = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = $clog2(LATENCY + 4);
   localparam logic [31:0] SPAN  = 32'(DEPTH_WORDS * 4);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   dmem_req_t          req_q, req_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               err_q, err_d;
   logic               ready_q, ready_d;
   logic               valid_q, valid_d;

   logic [31:0]        mem_q [DEPTH_WORDS];

   dmem_req_t          req_in_c;
   dmem_req_t          acc_c;
   logic [31:0]        off_c;
   logic [IDX_W-1:0]   idx_c;
   logic [31:0]        rword_c;
   logic               accept_c;
   logic               do_access_c;
   logic               err_c;
   logic               mem_we_c;
   logic [CNT_W-1:0]   busy_len_c;
   logic [3:0]         be_c;
   logic [31:0]        wdata_rep_c;
   logic [31:0]        rdata_ext_c;
   logic               misalign_c;
   logic               bad_size_c;

   assign req_in_c = '{wen: req_wen, addr: req_addr, wdata: req_wdata,
                       size: req_size, uns: req_unsigned};

   // With zero BUSY length the access happens on the accept edge, straight from the inputs.
   assign acc_c    = (state_q == S_IDLE) ? req_in_c : req_q;
   assign off_c    = acc_c.addr - BASE;
   assign idx_c    = off_c[IDX_W+1:2];
   assign rword_c  = mem_q[idx_c];
   assign accept_c = (state_q == S_IDLE) && req_valid;
   assign err_c    = (off_c >= SPAN) || misalign_c || bad_size_c;
   assign mem_we_c = do_access_c && acc_c.wen && !err_c && rst_n;

   ysyx_25020047_lsu_align u_align (
      .size        (acc_c.size),
      .addr_lo     (acc_c.addr[1:0]),
      .uns         (acc_c.uns),
      .wdata       (acc_c.wdata),
      .rword       (rword_c),
      .be_c        (be_c),
      .wdata_rep_c (wdata_rep_c),
      .rdata_ext_c (rdata_ext_c),
      .misalign_c  (misalign_c),
      .bad_size_c  (bad_size_c)
   );

`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted request.
   always_comb begin
      lfsr_d = lfsr_q;
      if (accept_c) begin
         lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign busy_len_c = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
   assign busy_len_c = CNT_W'(LATENCY);
`endif

   // Next-state, access strobe and response capture.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      req_d       = req_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      do_access_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               req_d = req_in_c;
               if (busy_len_c == '0) begin
                  state_d     = S_RESP;
                  do_access_c = 1'b1;
               end else begin
                  state_d = S_BUSY;
                  cnt_d   = busy_len_c;
               end
            end
         end
         S_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d     = S_RESP;
               do_access_c = 1'b1;
            end
         end
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (do_access_c) begin
         err_d   = err_c;
         rdata_d = (err_c || acc_c.wen) ? '0 : rdata_ext_c;
      end
      ready_d = (state_d == S_IDLE);
      valid_d = (state_d == S_RESP);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   // Byte-masked write port; storage is never reset.
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_c[b]) mem_q[idx_c][8*b +: 8] <= wdata_rep_c[8*b +: 8];
         end
      end
   end

   assign req_ready  = ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_25020047_dmem.sv
// Scoreboard bench for ysyx_25020047_dmem: one instance at LATENCY 2, one at LATENCY 0.
module tb_ysyx_25020047_dmem;

   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int unsigned DEPTH = 4096;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        sel;
   logic        req_valid;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic        resp_ready;

   logic        a_req_valid, a_resp_ready, a_req_ready, a_resp_valid, a_resp_err;
   logic        b_req_valid, b_resp_ready, b_req_ready, b_resp_valid, b_resp_err;
   logic [31:0] a_resp_rdata, b_resp_rdata;
   logic        cur_req_ready, cur_resp_valid, cur_resp_err;
   logic [31:0] cur_resp_rdata;

   exp_t        sb_q[$];
   logic [7:0]  mb [bit [32:0]];
   int          n_cmp;
   int          n_bad;

   assign a_req_valid    = req_valid & ~sel;
   assign b_req_valid    = req_valid & sel;
   assign a_resp_ready   = resp_ready & ~sel;
   assign b_resp_ready   = resp_ready & sel;
   assign cur_req_ready  = sel ? b_req_ready  : a_req_ready;
   assign cur_resp_valid = sel ? b_resp_valid : a_resp_valid;
   assign cur_resp_err   = sel ? b_resp_err   : a_resp_err;
   assign cur_resp_rdata = sel ? b_resp_rdata : a_resp_rdata;

   ysyx_25020047_dmem #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned), .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
   );

   ysyx_25020047_dmem #(.BASE(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsigned(req_unsigned), .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-granular reference memory, separate per instance via the sel key bit.
   function automatic exp_t model(input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size,
                                  input logic uns);
      exp_t        e;
      logic [31:0] off;
      logic [31:0] v;
      int          nb;
      off     = addr - BASE;
      nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      e.err   = (off >= 32'(DEPTH * 4)) || (size == 2'd3) || ((addr & 32'(nb - 1)) != 32'd0);
      e.rdata = 32'd0;
      if (!e.err) begin
         if (wen) begin
            for (int i = 0; i < nb; i++) mb[{sel, off + 32'(i)}] = wdata[8*i +: 8];
         end else begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v = v | (32'(mb[{sel, off + 32'(i)}]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
            e.rdata = v;
         end
      end
      return e;
   endfunction

   task automatic wait_ready();
      for (int i = 0; i < 20 && !cur_req_ready; i++) begin
         @(posedge clk);
         #1;
      end
      check("req_ready_idle", 32'(cur_req_ready), 32'd1);
   endtask

   // One request/response; with hold > 0 a conflicting store is also presented while in RESP.
   task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input int hold, input int lat_min);
      int   lat;
      exp_t e;
      wait_ready();
      req_wen      = wen;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      req_valid    = 1'b1;
      sb_q.push_back(model(wen, addr, wdata, size, uns));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!cur_resp_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
`ifdef YSYX_25020047_DMEM_RAND_DELAY_EN
      check("latency_in_range", 32'(lat >= lat_min && lat <= lat_min + 3), 32'd1);
`else
      check("latency", 32'(lat), 32'(lat_min));
`endif
      e = sb_q.pop_front();
      if (lat >= 20) return;
      for (int h = 0; h < hold; h++) begin
         req_wen   = 1'b1;
         req_addr  = 32'h8000_0020;
         req_wdata = 32'hBAD0_BAD0;
         req_size  = 2'd2;
         req_valid = 1'b1;
         check("hold_resp_valid", 32'(cur_resp_valid), 32'd1);
         check("hold_rdata", cur_resp_rdata, e.rdata);
         check("hold_req_ready", 32'(cur_req_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      check("rdata", cur_resp_rdata, e.rdata);
      check("err", 32'(cur_resp_err), 32'(e.err));
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check("resp_valid_drop", 32'(cur_resp_valid), 32'd0);
   endtask

   initial begin
      int lat_a;
      n_cmp        = 0;
      n_bad        = 0;
      lat_a        = 3;
      sel          = 1'b0;
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_wen      = 1'b0;
      req_addr     = 32'd0;
      req_wdata    = 32'd0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      resp_ready   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_req_ready", 32'(a_req_ready), 32'd1);
      check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
      check("rst_resp_rdata", a_resp_rdata, 32'd0);
      check("rst_resp_err", 32'(a_resp_err), 32'd0);
      check("rst0_resp_valid", 32'(b_resp_valid), 32'd0);

      // word store/load, then sub-word lanes
      xact(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0010, 32'd0,         2'd2, 1'b0, 0, lat_a);
      xact(1'b1, 32'h8000_0013, 32'h0000_0080, 2'd0, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0013, 32'd0,         2'd0, 1'b1, 0, lat_a);
      xact(1'b0, 32'h8000_0013, 32'd0,         2'd0, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0010, 32'd0,         2'd2, 1'b0, 0, lat_a);
      xact(1'b1, 32'h8000_0016, 32'h1234_8765, 2'd1, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0016, 32'd0,         2'd1, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0016, 32'd0,         2'd1, 1'b1, 0, lat_a);

      // error cases and range boundaries
      xact(1'b1, 32'h8000_0011, 32'h0000_5555, 2'd1, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0010, 32'd0,         2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0010, 32'd0,         2'd3, 1'b0, 0, lat_a);
      xact(1'b1, 32'h8000_0012, 32'h7777_7777, 2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h7FFF_FFFC, 32'd0,         2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_4000, 32'd0,         2'd2, 1'b0, 0, lat_a);
      xact(1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_3FFF, 32'd0,         2'd0, 1'b0, 0, lat_a);

      // back-pressure with a competing request held during RESP
      xact(1'b1, 32'h8000_0020, 32'h1111_2222, 2'd2, 1'b0, 0, lat_a);
      xact(1'b0, 32'h8000_0010, 32'd0,         2'd2, 1'b0, 5, lat_a);
      xact(1'b0, 32'h8000_0020, 32'd0,         2'd2, 1'b0, 0, lat_a);

      // reset while a store is in BUSY
      wait_ready();
      req_wen   = 1'b1;
      req_addr  = 32'h8000_0020;
      req_wdata = 32'h3333_4444;
      req_size  = 2'd2;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("midrst_resp_valid", 32'(a_resp_valid), 32'd0);
      check("midrst_req_ready", 32'(a_req_ready), 32'd1);
      xact(1'b0, 32'h8000_0020, 32'd0, 2'd2, 1'b0, 0, lat_a);

      // random stores then mixed-size loads over the same words
      for (int i = 0; i < 16; i++)
         xact(1'b1, BASE + 32'h100 + 32'(4 * i), $urandom, 2'd2, 1'b0, 0, lat_a);
      for (int i = 0; i < 34; i++)
         xact(1'b0, BASE + 32'h100 + 32'($urandom_range(0, 63)), 32'd0,
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, lat_a);

      // zero-latency instance
      sel = 1'b1;
      #1;
      xact(1'b1, 32'h8000_0040, 32'hA5C3_0F81, 2'd2, 1'b0, 0, 1);
      xact(1'b0, 32'h8000_0040, 32'd0,         2'd2, 1'b0, 0, 1);
      xact(1'b0, 32'h8000_0043, 32'd0,         2'd0, 1'b0, 0, 1);
      xact(1'b0, 32'h8000_0042, 32'd0,         2'd1, 1'b1, 0, 1);
      xact(1'b0, 32'h8000_0041, 32'd0,         2'd1, 1'b0, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
